// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
//
// Packet-level round-robin merge of C_NUM_SLAVES AXI4-Stream inputs onto one
// registered AXI4-Stream master. Once an input is granted, it keeps the grant
// until its TLAST beat is accepted, so packets are never interleaved. The
// search for the next input starts one position after the input granted last.
//
// Ports
//   aclk           : clock, rising edge
//   aresetn        : asynchronous active-low reset
//   s_axis_tvalid  : per-input TVALID (bit i = input i)
//   s_axis_tready  : per-input TREADY, only the granted bit can be set
//   s_axis_tlast   : per-input TLAST
//   s_axis_tdata   : input i on bits [i*W +: W]
//   m_axis_tvalid  : merged TVALID (registered)
//   m_axis_tready  : downstream TREADY
//   m_axis_tlast   : merged TLAST (registered)
//   m_axis_tdata   : merged TDATA (registered)
//   grant_id       : index of the input currently or last granted
//   busy           : high while a packet holds the grant
// -----------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int C_AXIS_DATA_WIDTH = 128,
  parameter int C_NUM_SLAVES      = 4,
  parameter int C_GRANT_W         = (C_NUM_SLAVES > 1) ? $clog2(C_NUM_SLAVES) : 1
) (
  input  logic                                      aclk,
  input  logic                                      aresetn,
  input  logic [C_NUM_SLAVES-1:0]                   s_axis_tvalid,
  output logic [C_NUM_SLAVES-1:0]                   s_axis_tready,
  input  logic [C_NUM_SLAVES-1:0]                   s_axis_tlast,
  input  logic [C_NUM_SLAVES*C_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_GRANT_W-1:0]                      grant_id,
  output logic                                      busy
);

  localparam int W = C_AXIS_DATA_WIDTH;
  localparam int N = C_NUM_SLAVES;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                 state_r;
  logic [C_GRANT_W-1:0]   grant_r;
  logic [C_GRANT_W-1:0]   last_grant_r;
  logic                   busy_r;
  logic                   m_valid_r;
  logic                   m_last_r;
  logic [W-1:0]           m_data_r;

  logic [C_GRANT_W-1:0]   pick_s;
  logic [N-1:0]           tready_s;
  logic                   sel_last_s;
  logic [W-1:0]           sel_data_s;
  logic                   in_hs_s;
  logic                   out_free_s;

  // First requesting input strictly after 'last', wrapping around. The
  // previously granted input is checked last, giving it the lowest priority.
  function automatic logic [C_GRANT_W-1:0] rr_pick(
    input logic [N-1:0]         req,
    input logic [C_GRANT_W-1:0] last
  );
    logic [C_GRANT_W-1:0] pick;
    logic                 found;
    int                   idx;
    pick  = {C_GRANT_W{1'b0}};
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k >= N) ? (int'(last) + k - N) : (int'(last) + k);
      if (!found && req[idx]) begin
        pick  = C_GRANT_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // The output register can take a new beat when it is empty or draining now.
  assign out_free_s = !m_valid_r || m_axis_tready;
  assign pick_s     = rr_pick(s_axis_tvalid, last_grant_r);

  // Ready for the granted input only, and mux of that input's last/data.
  // Ready never looks at s_axis_tvalid, so there is no valid->ready path.
  always_comb begin
    tready_s   = {N{1'b0}};
    sel_last_s = 1'b0;
    sel_data_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      tready_s[i] = (state_r == ST_LOCKED) && (grant_r == C_GRANT_W'(i)) && out_free_s;
      sel_last_s  = sel_last_s | ((grant_r == C_GRANT_W'(i)) & s_axis_tlast[i]);
      sel_data_s  = sel_data_s | ({W{grant_r == C_GRANT_W'(i)}} & s_axis_tdata[i*W +: W]);
    end
  end

  assign in_hs_s = |(s_axis_tvalid & tready_s);

  // Arbitration state machine: grant in IDLE, release on the accepted TLAST.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r      <= ST_IDLE;
      grant_r      <= {C_GRANT_W{1'b0}};
      last_grant_r <= C_GRANT_W'(N - 1);
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|s_axis_tvalid) begin
            state_r      <= ST_LOCKED;
            grant_r      <= pick_s;
            last_grant_r <= pick_s;
            busy_r       <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_LOCKED: begin
          if (in_hs_s && sel_last_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_LOCKED;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output register; it holds while stalled and drains after IDLE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_data_r  <= {W{1'b0}};
    end else if (in_hs_s) begin
      m_valid_r <= 1'b1;
      m_last_r  <= sel_last_s;
      m_data_r  <= sel_data_s;
    end else if (m_valid_r && m_axis_tready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  assign s_axis_tready = tready_s;
  assign m_axis_tvalid = m_valid_r;
  assign m_axis_tlast  = m_last_r;
  assign m_axis_tdata  = m_data_r;
  assign grant_id      = grant_r;
  assign busy          = busy_r;

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that merges `C_NUM_SLAVES` AXI4-Stream inputs onto one AXI4-Stream master output. It is placed in front of a shared stream consumer, such as a DMA write channel or an output FIFO. A grant is held for a whole packet, from grant until the beat carrying `tlast` is accepted, so packets are never interleaved. The master output is fully registered and satisfies the stream master rules checked by the team's AXIS master assertion checker: TDATA and TLAST stay stable while TVALID is high and TREADY is low, and TVALID stays high until the handshake.

## Interface
- `C_AXIS_DATA_WIDTH`, default 128: TDATA width per stream.
- `C_NUM_SLAVES`, default 4: number of input streams, range 1..16.
- `C_GRANT_W`, default `max(1, $clog2(C_NUM_SLAVES))`: width of `grant_id`. Derived; do not override.

Ports (clock and reset first):
- `aclk`, in, 1: the single clock. All logic is on its rising edge.
- `aresetn`, in, 1: reset, asynchronous, active-low.
- `s_axis_tvalid`, in, `C_NUM_SLAVES`: per-input TVALID. Bit i belongs to input i.
- `s_axis_tready`, out, `C_NUM_SLAVES`: per-input TREADY.
- `s_axis_tlast`, in, `C_NUM_SLAVES`: per-input TLAST.
- `s_axis_tdata`, in, `C_NUM_SLAVES*C_AXIS_DATA_WIDTH`: input i occupies bits `[i*W +: W]`.
- `m_axis_tvalid`, out, 1: merged output TVALID, registered.
- `m_axis_tready`, in, 1: downstream TREADY.
- `m_axis_tlast`, out, 1: merged output TLAST, registered.
- `m_axis_tdata`, out, `C_AXIS_DATA_WIDTH`: merged output TDATA, registered.
- `grant_id`, out, `C_GRANT_W`: index of the input currently or last granted.
- `busy`, out, 1: high while in LOCKED.

## Operation
- State machine with two states, IDLE and LOCKED.
- **IDLE**
  - `s_axis_tready` is all zeros.
  - If any `s_axis_tvalid` bit is set, select the first set bit scanning upward from `last_grant+1`, wrapping modulo `C_NUM_SLAVES`.
  - On the next edge: `grant_id` takes the selected index, `last_grant` takes the selected index, and the state goes to LOCKED.
  - If no bit is set, stay in IDLE.
- **LOCKED**
  - `s_axis_tready[grant_id] = !m_axis_tvalid || m_axis_tready`. All other TREADY bits are 0.
  - On an input handshake (`s_axis_tvalid[g] && s_axis_tready[g]`), the output register loads that input's TDATA and TLAST and sets `m_axis_tvalid = 1`.
  - If there is no input handshake and there is an output handshake, `m_axis_tvalid` goes to 0.
  - If the accepted input beat has TLAST = 1, the state goes to IDLE on the same edge.
- The output register is one entry deep. It keeps draining after the state returns to IDLE.
- The output register never changes while `m_axis_tvalid && !m_axis_tready`.
- A single-beat packet (TLAST on the first beat) is legal: LOCKED lasts until that one beat is accepted.
- Inputs without a grant are never acknowledged, and their data is ignored.
- With `C_NUM_SLAVES = 1`, the block behaves as a registered pipe with one idle cycle between packets. `grant_id` stays 0.
- An input that drops TVALID while it holds a grant violates the protocol. The arbiter stays in LOCKED and waits for it; there is no timeout.

## Timing
- **Reset**, while `aresetn` is low, applied asynchronously:
  - `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `m_axis_tdata = 0`.
  - `s_axis_tready = 0`, `grant_id = 0`, `busy = 0`, state = IDLE.
  - `last_grant = C_NUM_SLAVES-1`, so input 0 has first priority after reset.
- **Reset mid-packet**: the packet is abandoned and the output beat is dropped. After release, arbitration restarts from input 0.
- **Data latency**: an input beat accepted at edge t appears on `m_axis_*` in the cycle after edge t.
- **Grant latency**: a request seen in IDLE in cycle c gives `s_axis_tready` high in cycle c+1.
- **Gap between packets**: if the TLAST beat is accepted at edge t, the state is IDLE in cycle t+1. The earliest next acceptance is at edge t+2. Back-to-back streaming therefore loses one cycle per packet.
- **Combinational paths**: `s_axis_tready` depends only on the state, `grant_id`, `m_axis_tvalid` and `m_axis_tready`. There is no path from `s_axis_tvalid` to `s_axis_tready`.
- `busy` and `grant_id` are registered.

## Test plan
- **Reset values**: hold `aresetn = 0` for 3 cycles, then release with no requests. Outputs must be: `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `s_axis_tready = 4'b0000`, `grant_id = 0`, `busy = 0`.
- **Round-robin**: with `m_axis_tready = 1`, all four inputs request continuously and each sends 2-beat packets. The grant order must be 0, 1, 2, 3, 0, and no packet may be interleaved with another.
- **Backpressure**: input 2 sends the 3-beat packet 0xA, 0xB, 0xC (TLAST on 0xC) while `m_axis_tready` is held at 0 for 4 cycles.
  - `m_axis_tdata` must stay at 0xA and `m_axis_tvalid` must stay high during the stall.
  - `s_axis_tready[2]` must be 0 during the stall.
  - The output must then be 0xA, 0xB, 0xC with TLAST only on 0xC.
- **Single-beat packets**: input 1 sends alternating single-beat packets while input 3 also requests. The grants must alternate 1, 3, 1, 3, with exactly one IDLE cycle between packets.
- **Late request**: input 0 requests one cycle after input 3 has been granted. Input 0 must wait until input 3's TLAST has been accepted, and is granted after that.
- **Reset mid-packet**: assert `aresetn = 0` asynchronously in the middle of the 2nd beat of a packet. `m_axis_tvalid` must drop immediately, before the next clock edge. After release, an input-2 request must be granted with `grant_id = 2` and no stale beat may appear.
